// File: rtl/step_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// step_pulse_sequencer
//
// Programmable step-pulse generator for the motor/stepper drive path. A
// fractional phase accumulator (modulus CLK_HZ) produces an exact average
// pulse rate. The block runs either a single fixed rate or a profile of
// (rate, duration) segments from a small loadable table, played once or
// looped. pulse_out is a one-cycle strobe on clk, intended as an enable.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start        level: 1 = run, 0 = stop and return to IDLE
//   mode         00 fixed, 01 profile once, 10 profile loop, 11 as 00
//   fixed_rate   pulse rate in Hz used in fixed mode (sampled every cycle)
//   cfg_we       profile table write strobe
//   cfg_addr     profile table write address
//   cfg_rate     segment rate in Hz
//   cfg_dur      segment duration in seconds; 0 marks end of profile
//   pulse_out    one-cycle step strobe
//   sec_tick     one-cycle strobe every CLK_HZ running cycles
//   busy         running (fixed or profile)
//   done         profile finished, waiting for start to drop
//   cur_seg      index of the active profile segment
//   pulse_cnt    pulses emitted since the last run start (wraps)
// ---------------------------------------------------------------------------
module step_pulse_sequencer #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned SEG_DEPTH = 16,
  parameter int unsigned RATE_W    = 16,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [RATE_W-1:0]            fixed_rate,
  input  logic                         cfg_we,
  input  logic [$clog2(SEG_DEPTH)-1:0] cfg_addr,
  input  logic [RATE_W-1:0]            cfg_rate,
  input  logic [DUR_W-1:0]             cfg_dur,
  output logic                         pulse_out,
  output logic                         sec_tick,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(SEG_DEPTH)-1:0] cur_seg,
  output logic [CNT_W-1:0]             pulse_cnt
);

  localparam int unsigned IDX_W = $clog2(SEG_DEPTH);
  localparam int unsigned SEC_W = $clog2(CLK_HZ);
  // One extra bit so acc + rate (< 1.5 * CLK_HZ) never overflows.
  localparam int unsigned ACC_W = SEC_W + 1;

  localparam logic [ACC_W-1:0] MODULUS  = ACC_W'(CLK_HZ);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN_FIXED = 2'd1,
    S_RUN_SEQ   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Profile table (not reset; contents undefined until written)
  logic [RATE_W-1:0] tbl_rate [SEG_DEPTH];
  logic [DUR_W-1:0]  tbl_dur  [SEG_DEPTH];

  // Working copy of the active segment
  logic [RATE_W-1:0] seg_rate;
  logic [DUR_W-1:0]  rem;
  logic              loop_mode;

  logic [ACC_W-1:0]  acc;
  logic [SEC_W-1:0]  sec_cnt;

  // FSM control strobes
  logic              clr_run;
  logic              run_step;
  logic              seg_load;
  logic [IDX_W-1:0]  seg_idx;
  logic              rem_dec;
  logic [IDX_W-1:0]  nxt_idx;

  // Stage p0 (combinational accumulator step)
  logic              vld_p0;
  logic [RATE_W-1:0] rate_p0;
  logic [ACC_W:0]    step_p0;
  logic              carry_p0;
  logic [ACC_W-1:0]  acc_nxt_p0;

  // Modular add: returns {carry, (a + r) mod CLK_HZ}. Valid because a is
  // always below CLK_HZ and r is at most CLK_HZ/2.
  function automatic logic [ACC_W:0] acc_wrap(
    input logic [ACC_W-1:0]  a,
    input logic [RATE_W-1:0] r
  );
    logic [ACC_W-1:0] sum;
    sum = a + ACC_W'(r);
    if (sum >= MODULUS) begin
      return {1'b1, sum - MODULUS};
    end
    return {1'b0, sum};
  endfunction

  assign nxt_idx = cur_seg + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_run   = 1'b0;
    run_step  = 1'b0;
    seg_load  = 1'b0;
    seg_idx   = '0;
    rem_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr_run = 1'b1;
          if (mode == 2'b01 || mode == 2'b10) begin
            if (tbl_dur[0] == '0) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_RUN_SEQ;
              seg_load  = 1'b1;
            end
          end else begin
            state_nxt = S_RUN_FIXED;
          end
        end
      end
      S_RUN_FIXED: begin
        if (!start) begin
          state_nxt = S_IDLE;
        end else begin
          run_step = 1'b1;
        end
      end
      S_RUN_SEQ: begin
        if (!start) begin
          state_nxt = S_IDLE;
        end else begin
          run_step = 1'b1;
          // Segment bookkeeping acts on the cycle that shows sec_tick, so
          // the new segment becomes visible one cycle after the final tick.
          if (sec_tick) begin
            if (rem > DUR_W'(1)) begin
              rem_dec = 1'b1;
            end else if (nxt_idx != '0 && tbl_dur[nxt_idx] != '0) begin
              seg_load = 1'b1;
              seg_idx  = nxt_idx;
            end else if (loop_mode && tbl_dur[0] != '0) begin
              seg_load = 1'b1;
              seg_idx  = '0;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign vld_p0     = run_step;
  assign rate_p0    = (state == S_RUN_FIXED) ? fixed_rate : seg_rate;
  assign step_p0    = acc_wrap(acc, rate_p0);
  assign carry_p0   = step_p0[ACC_W];
  assign acc_nxt_p0 = step_p0[ACC_W-1:0];

  // Stage p1 (registered outputs, counters)
  // pulse_out and sec_tick default low, so stopping, IDLE and DONE never
  // strobe. The last running cycle before DONE may still register a pulse,
  // which is then visible in the first DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sec_cnt   <= '0;
      sec_tick  <= 1'b0;
      pulse_out <= 1'b0;
      pulse_cnt <= '0;
      cur_seg   <= '0;
      rem       <= '0;
      loop_mode <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      sec_tick  <= 1'b0;
      if (clr_run) begin
        acc       <= '0;
        sec_cnt   <= '0;
        pulse_cnt <= '0;
        cur_seg   <= '0;
        loop_mode <= (mode == 2'b10);
      end else if (vld_p0) begin
        acc       <= acc_nxt_p0;
        pulse_out <= carry_p0;
        if (carry_p0) begin
          pulse_cnt <= pulse_cnt + CNT_W'(1);
        end
        if (sec_cnt == SEC_LAST) begin
          sec_cnt  <= '0;
          sec_tick <= 1'b1;
        end else begin
          sec_cnt <= sec_cnt + SEC_W'(1);
        end
      end
      if (seg_load) begin
        cur_seg <= seg_idx;
        rem     <= tbl_dur[seg_idx];
      end else if (rem_dec) begin
        rem <= rem - DUR_W'(1);
      end
    end
  end

  // Table writes are independent of state. A rewrite of the active entry
  // only matters at its next load because seg_rate holds the live copy;
  // a load and a write in the same cycle load the old contents.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_rate[cfg_addr] <= cfg_rate;
      tbl_dur[cfg_addr]  <= cfg_dur;
    end
    if (seg_load) begin
      seg_rate <= tbl_rate[seg_idx];
    end
  end

  assign busy = (state == S_RUN_FIXED) || (state == S_RUN_SEQ);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_step_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_sequencer
//
// Directed testbench for step_pulse_sequencer at CLK_HZ = 1000. A behavioural
// model tracks elapsed running cycles, segment end times and the fractional
// accumulator; one compare process checks every output each cycle, and the
// directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_step_pulse_sequencer;

  localparam int CLK_HZ    = 1000;
  localparam int SEG_DEPTH = 4;
  localparam int RATE_W    = 8;
  localparam int DUR_W     = 4;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = $clog2(SEG_DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [RATE_W-1:0] fixed_rate = '0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_addr = '0;
  logic [RATE_W-1:0] cfg_rate = '0;
  logic [DUR_W-1:0]  cfg_dur = '0;
  logic              pulse_out;
  logic              sec_tick;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  cur_seg;
  logic [CNT_W-1:0]  pulse_cnt;

  int n_total = 0;
  int n_bad   = 0;

  step_pulse_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .SEG_DEPTH(SEG_DEPTH),
    .RATE_W   (RATE_W),
    .DUR_W    (DUR_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .fixed_rate(fixed_rate),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_rate  (cfg_rate),
    .cfg_dur   (cfg_dur),
    .pulse_out (pulse_out),
    .sec_tick  (sec_tick),
    .busy      (busy),
    .done      (done),
    .cur_seg   (cur_seg),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: time is counted in running cycles since the run
  // began; a segment ends once its duration in seconds has elapsed plus
  // the one-cycle bookkeeping delay after the final second tick.
  // ------------------------------------------------------------------
  localparam int P_IDLE = 0, P_FIXED = 1, P_SEQ = 2, P_DONE = 3;
  int               m_phase = P_IDLE;
  int               m_k = 0;
  int               m_end = 0;
  int               m_acc = 0;
  int               m_rate = 0;
  int               m_r = 0;
  int               m_nxt = 0;
  int               m_seg = 0;
  bit               m_loop = 1'b0;
  bit               m_pulse = 1'b0;
  bit               m_tick = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               t_rate [SEG_DEPTH];
  int               t_dur  [SEG_DEPTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_pulse = 1'b0;
      m_tick  = 1'b0;
      m_cnt   = '0;
      m_seg   = 0;
      m_acc   = 0;
      m_k     = 0;
    end else begin
      m_pulse = 1'b0;
      m_tick  = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (start) begin
            m_acc  = 0;
            m_k    = 0;
            m_cnt  = '0;
            m_seg  = 0;
            m_loop = (mode == 2'b10);
            if (mode == 2'b01 || mode == 2'b10) begin
              if (t_dur[0] == 0) begin
                m_phase = P_DONE;
              end else begin
                m_phase = P_SEQ;
                m_rate  = t_rate[0];
                m_end   = t_dur[0] * CLK_HZ + 1;
              end
            end else begin
              m_phase = P_FIXED;
            end
          end
        end
        P_FIXED, P_SEQ: begin
          if (!start) begin
            m_phase = P_IDLE;
          end else begin
            m_k++;
            m_r = (m_phase == P_FIXED) ? int'(fixed_rate) : m_rate;
            m_acc += m_r;
            if (m_acc >= CLK_HZ) begin
              m_acc  -= CLK_HZ;
              m_pulse = 1'b1;
              m_cnt++;
            end
            m_tick = ((m_k % CLK_HZ) == 0);
            if (m_phase == P_SEQ && m_k == m_end) begin
              m_nxt = (m_seg + 1) % SEG_DEPTH;
              if (m_nxt != 0 && t_dur[m_nxt] != 0) begin
                m_seg  = m_nxt;
                m_rate = t_rate[m_nxt];
                m_end += t_dur[m_nxt] * CLK_HZ;
              end else if (m_loop && t_dur[0] != 0) begin
                m_seg  = 0;
                m_rate = t_rate[0];
                m_end += t_dur[0] * CLK_HZ;
              end else begin
                m_phase = P_DONE;
              end
            end
          end
        end
        default: begin
          if (!start) m_phase = P_IDLE;
        end
      endcase
      if (cfg_we) begin
        t_rate[cfg_addr] = int'(cfg_rate);
        t_dur[cfg_addr]  = int'(cfg_dur);
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-cycle compare plus observation counters for window checks
  // ------------------------------------------------------------------
  int cyc = 0;
  int obs_pulses = 0;
  int obs_ticks = 0;
  int obs_wide = 0;
  int last_pulse = -1;
  int min_gap = 1000000;
  int max_gap = 0;
  bit prev_pulse = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("pulse_out", pulse_out, m_pulse);
    chk("sec_tick", sec_tick, m_tick);
    chk("busy", busy, (m_phase == P_FIXED || m_phase == P_SEQ));
    chk("done", done, (m_phase == P_DONE));
    chk("cur_seg", cur_seg, m_seg);
    chk("pulse_cnt", pulse_cnt, m_cnt);
    if (pulse_out) obs_pulses++;
    if (sec_tick) obs_ticks++;
    if (pulse_out && prev_pulse) obs_wide++;
    prev_pulse = pulse_out;
    if (!busy) begin
      last_pulse = -1;
      min_gap    = 1000000;
      max_gap    = 0;
    end else if (pulse_out) begin
      if (last_pulse >= 0) begin
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
        if (cyc - last_pulse > max_gap) max_gap = cyc - last_pulse;
      end
      last_pulse = cyc;
    end
  end

  // ------------------------------------------------------------------
  // Directed sequence (inputs change 1 time unit after the falling edge)
  // ------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int r, input int d);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_rate = RATE_W'(r);
    cfg_dur  = DUR_W'(d);
    wait_cyc(1);
    cfg_we   = 1'b0;
  endtask

  int snap_p;
  int snap_t;
  int snap_w;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst pulse_out", pulse_out, 0);
    chk("rst sec_tick", sec_tick, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cur_seg", cur_seg, 0);
    chk("rst pulse_cnt", pulse_cnt, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // Fixed rate 32 Hz for 3000 running cycles
    snap_w = obs_wide;
    fixed_rate = 8'd32; mode = 2'b00; start = 1'b1;
    wait_cyc(1 + 2999);
    chk("fixed cnt@2999", pulse_cnt, 95);
    wait_cyc(1);
    chk("fixed cnt@3000", pulse_cnt, 96);
    chk("fixed busy", busy, 1);
    chk("fixed min gap", min_gap, 31);
    chk("fixed max gap", max_gap, 32);
    chk("fixed width", obs_wide - snap_w, 0);
    start = 1'b0;
    wait_cyc(1);
    chk("fixed stop busy", busy, 0);
    chk("fixed cnt hold", pulse_cnt, 96);
    wait_cyc(2);

    // Profile once {(20,2),(70,1),(0,0)}
    wr(0, 20, 2); wr(1, 70, 1); wr(2, 0, 0); wr(3, 0, 0);
    mode = 2'b01; start = 1'b1;
    wait_cyc(1 + 2000);
    chk("once seg0 cnt", pulse_cnt, 40);
    chk("once seg0 idx", cur_seg, 0);
    wait_cyc(1);
    chk("once seg1 idx", cur_seg, 1);
    wait_cyc(999);
    chk("once done@3000", done, 0);
    chk("once cnt@3000", pulse_cnt, 109);
    wait_cyc(1);
    chk("once done@3001", done, 1);
    chk("once busy@3001", busy, 0);
    chk("once cnt@3001", pulse_cnt, 110);
    wait_cyc(5);
    chk("once done hold", done, 1);
    start = 1'b0;
    wait_cyc(1);
    chk("once stop done", done, 0);
    chk("once stop busy", busy, 0);
    wait_cyc(2);

    // Profile loop {(10,1),(30,1),(0,0)} for 4 s
    wr(0, 10, 1); wr(1, 30, 1); wr(2, 0, 0); wr(3, 0, 0);
    mode = 2'b10; start = 1'b1;
    wait_cyc(1 + 1000);
    chk("loop cnt@1000", pulse_cnt, 10);
    wait_cyc(1);
    chk("loop idx@1001", cur_seg, 1);
    wait_cyc(1000);
    chk("loop idx@2001", cur_seg, 0);
    chk("loop cnt@2001", pulse_cnt, 40);
    wait_cyc(1001);
    chk("loop idx@3002", cur_seg, 1);
    chk("loop cnt@3002", pulse_cnt, 50);
    wait_cyc(998);
    chk("loop cnt@4000", pulse_cnt, 79);
    wait_cyc(1);
    chk("loop cnt@4001", pulse_cnt, 80);
    chk("loop busy", busy, 1);
    chk("loop done", done, 0);
    start = 1'b0;
    wait_cyc(2);

    // Empty profile: DONE right after the entry cycle
    wr(0, 50, 0);
    mode = 2'b01; start = 1'b1;
    wait_cyc(1);
    chk("empty done", done, 1);
    chk("empty busy", busy, 0);
    chk("empty cnt", pulse_cnt, 0);
    start = 1'b0;
    wait_cyc(2);

    // Rate 0 in reserved mode 11: ticks but no pulses
    fixed_rate = 8'd0; mode = 2'b11; start = 1'b1;
    snap_p = obs_pulses; snap_t = obs_ticks;
    wait_cyc(1 + 3000);
    chk("zero rate pulses", obs_pulses - snap_p, 0);
    chk("zero rate ticks", obs_ticks - snap_t, 3);
    chk("zero rate busy", busy, 1);
    start = 1'b0;
    wait_cyc(2);

    // Rewrite of active segment applies only on loop reload
    wr(0, 20, 2); wr(1, 0, 0);
    mode = 2'b10; start = 1'b1;
    wait_cyc(1 + 500);
    wr(0, 50, 2);
    wait_cyc(1499);
    chk("rewrite cnt@2000", pulse_cnt, 40);
    wait_cyc(1001);
    chk("rewrite cnt@3001", pulse_cnt, 90);
    chk("rewrite idx", cur_seg, 0);
    start = 1'b0;
    wait_cyc(2);

    // Asynchronous reset mid-segment, then restart
    wr(0, 20, 2); wr(1, 70, 1); wr(2, 0, 0);
    mode = 2'b01; start = 1'b1;
    wait_cyc(1 + 1500);
    #2 rst = 1'b1;
    #1;
    chk("arst pulse_out", pulse_out, 0);
    chk("arst sec_tick", sec_tick, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst cur_seg", cur_seg, 0);
    chk("arst pulse_cnt", pulse_cnt, 0);
    start = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    start = 1'b1;
    wait_cyc(1 + 1);
    chk("restart cnt@1", pulse_cnt, 0);
    chk("restart busy", busy, 1);
    wait_cyc(49);
    chk("restart cnt@50", pulse_cnt, 1);
    chk("restart idx", cur_seg, 0);
    start = 1'b0;
    wait_cyc(2);

    // pulse_cnt wraps modulo 2^CNT_W
    fixed_rate = 8'd200; mode = 2'b00; start = 1'b1;
    wait_cyc(1 + 1280);
    chk("wrap cnt@1280", pulse_cnt, 0);
    wait_cyc(720);
    chk("wrap cnt@2000", pulse_cnt, 144);
    start = 1'b0;
    wait_cyc(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
